axi_lite_master: RTL and testbench



---
 rtl/axi_lite_master.sv | 201 ++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI4-lite master bridge: accepts one request at a time on a valid/ready port, drives the
// AW/W/B or AR/R channels, and reports completion with a single-cycle response pulse.
module axi_lite_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    // Core-side request/response port
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // Write address channel
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    // Write data channel
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    // Write response channel
    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic [1:0]              BRESP,
    // Read address channel
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    // Read data channel
    input  logic                    RVALID,
    output logic                    RREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StWaddrData,
        StWresp,
        StRaddr,
        StRdata
    } state_e;

    state_e                  state_q, state_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]    wstrb_q, wstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    // Only bit 1 of the response codes distinguishes error from success.
    logic unused_resp;
    assign unused_resp = BRESP[0] ^ RRESP[0];

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_write) begin
                        state_d   = StWaddrData;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_strb;
                    end else begin
                        state_d   = StRaddr;
                        arvalid_d = 1'b1;
                        araddr_d  = req_addr;
                    end
                end
            end
            StWaddrData: begin
                // A cleared VALID doubles as the per-channel done flag, so a finished
                // channel is never re-raised while the other one is still waiting.
                if (AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = StWresp;
                    bready_d = 1'b1;
                end
            end
            StWresp: begin
                if (BVALID) begin
                    state_d     = StIdle;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = BRESP[1];
                    awaddr_d    = '0;
                    wdata_d     = '0;
                    wstrb_d     = '0;
                end
            end
            StRaddr: begin
                if (ARREADY) begin
                    state_d   = StRdata;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdata: begin
                if (RVALID) begin
                    state_d     = StIdle;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = RDATA;
                    rsp_err_d   = RRESP[1];
                    araddr_d    = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= StIdle;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign AWVALID   = awvalid_q;
    assign AWADDR    = awaddr_q;
    assign AWPROT    = 3'b000;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = araddr_q;
    assign ARPROT    = 3'b000;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a configurable AXI4-lite responder plus a transaction-level model
// of expected responses, latencies and handshake counts.
module tb_axi_lite_master;

    logic        ACLK;
    logic        ARESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    axi_lite_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .AWPROT    (AWPROT),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BRESP     (BRESP),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .ARPROT    (ARPROT),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Responder configuration, set by the main sequence before each transaction.
    int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] rdata_cfg;
    bit          slave_flush;

    // Observations gathered by the responder.
    int          n_aw, n_w, n_b, n_ar, n_r, n_rsp, violations;
    logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
    logic [3:0]  seen_wstrb;

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input bit wr);
        int m;
        m = (aw_lat > w_lat) ? aw_lat : w_lat;
        return wr ? (3 + m + b_lat) : (3 + ar_lat + r_lat);
    endfunction

    // Responder: samples mid-cycle after the falling edge, drives just after the rising edge.
    initial begin : slave
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
        bit aw_seen, w_seen, b_arm, r_arm;
        bit aw_pend, w_pend, ar_pend;
        int b_cnt, r_cnt, aw_wait, w_wait, ar_wait;
        logic [31:0] aw_prev, w_prev, ar_prev;
        logic [3:0]  s_prev;
        AWREADY = 0; WREADY = 0; ARREADY = 0;
        BVALID = 0; BRESP = 0; RVALID = 0; RRESP = 0; RDATA = 0;
        aw_seen = 0; w_seen = 0; b_arm = 0; r_arm = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
        aw_prev = 0; w_prev = 0; ar_prev = 0; s_prev = 0;
        forever begin
            @(negedge ACLK);
            #2;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            ar_hs = ARVALID && ARREADY;
            b_hs  = BVALID && BREADY;
            r_hs  = RVALID && RREADY;
            if (ARESET) begin
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if (aw_pend && (!AWVALID || AWADDR !== aw_prev)) violations++;
                if (w_pend && (!WVALID || WDATA !== w_prev || WSTRB !== s_prev)) violations++;
                if (ar_pend && (!ARVALID || ARADDR !== ar_prev)) violations++;
                if ((AWVALID || WVALID) && ARVALID) violations++;
                if (AWPROT !== 3'b000 || ARPROT !== 3'b000) violations++;
                aw_pend = AWVALID && !AWREADY; aw_prev = AWADDR;
                w_pend  = WVALID && !WREADY;   w_prev = WDATA; s_prev = WSTRB;
                ar_pend = ARVALID && !ARREADY; ar_prev = ARADDR;
                if (aw_hs) begin n_aw++; seen_awaddr = AWADDR; aw_seen = 1; end
                if (w_hs) begin n_w++; seen_wdata = WDATA; seen_wstrb = WSTRB; w_seen = 1; end
                if (ar_hs) begin n_ar++; seen_araddr = ARADDR; end
                if (b_hs) n_b++;
                if (r_hs) n_r++;
                if (rsp_valid) n_rsp++;
            end
            @(posedge ACLK);
            #1;
            if (slave_flush) begin
                BVALID = 0; RVALID = 0; b_arm = 0; r_arm = 0; aw_seen = 0; w_seen = 0;
            end else begin
                if (b_hs) BVALID = 0;
                if (r_hs) RVALID = 0;
                if (aw_seen && w_seen) begin
                    aw_seen = 0; w_seen = 0; b_arm = 1; b_cnt = b_lat;
                end
                if (b_arm) begin
                    if (b_cnt == 0) begin BVALID = 1; BRESP = bresp_cfg; b_arm = 0; end
                    else b_cnt--;
                end
                if (ar_hs) begin r_arm = 1; r_cnt = r_lat; end
                if (r_arm) begin
                    if (r_cnt == 0) begin
                        RVALID = 1; RDATA = rdata_cfg; RRESP = rresp_cfg; r_arm = 0;
                    end else r_cnt--;
                end
            end
            if (AWVALID) begin AWREADY = (aw_wait >= aw_lat); aw_wait++; end
            else begin AWREADY = 0; aw_wait = 0; end
            if (WVALID) begin WREADY = (w_wait >= w_lat); w_wait++; end
            else begin WREADY = 0; w_wait = 0; end
            if (ARVALID) begin ARREADY = (ar_wait >= ar_lat); ar_wait++; end
            else begin ARREADY = 0; ar_wait = 0; end
        end
    end

    // One complete transaction from an idle start; called at a falling edge.
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        int cyc, lat, aw0, w0, b0, ar0, r0, p0;
        logic [31:0] exp_rd;
        logic        exp_err;
        lat = exp_latency(wr);
        exp_rd  = wr ? 32'h0 : rdata_cfg;
        exp_err = wr ? bresp_cfg[1] : rresp_cfg[1];
        aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r; p0 = n_rsp;
        chk("idle_ready", req_ready, 1);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
        @(negedge ACLK);
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_strb = 4'($urandom);
        if (wr) begin
            chk("c1_valids", {AWVALID, WVALID, ARVALID}, 3'b110);
            chk("c1_awaddr_wdata", {AWADDR, WDATA}, {a, d});
            chk("c1_wstrb", WSTRB, s);
        end else begin
            chk("c1_valids", {AWVALID, WVALID, ARVALID}, 3'b001);
            chk("c1_araddr", ARADDR, a);
        end
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin
            @(negedge ACLK);
            cyc++;
            if (wr && cyc == 2 && aw_lat == 0 && w_lat == 0) chk("c2_bready", BREADY, 1);
            if (wr && cyc == 2 && aw_lat >= 2 && w_lat == 0)
                chk("w_dropped_aw_held", {AWVALID, WVALID, BREADY}, 3'b100);
        end
        chk("latency", cyc, lat);
        chk("rsp_data_err", {rsp_rdata, rsp_err}, {exp_rd, exp_err});
        @(negedge ACLK);
        chk("rsp_one_cycle", {rsp_valid, req_ready}, 2'b01);
        chk("hs_counts", {8'(n_aw - aw0), 8'(n_w - w0), 8'(n_b - b0), 8'(n_ar - ar0),
                          8'(n_r - r0), 8'(n_rsp - p0)},
            {8'(wr), 8'(wr), 8'(wr), 8'(!wr), 8'(!wr), 8'd1});
        if (wr) chk("seen_write", {seen_awaddr, seen_wdata, 4'h0, seen_wstrb}, {a, d, 4'h0, s});
        else chk("seen_read", seen_araddr, a);
    endtask

    initial begin : main
        int cyc, p0, aw0, r0;
        bit bad;
        logic [31:0] a_wr, a_rd, d;
        checks = 0; failures = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_rsp = 0; violations = 0;
        seen_awaddr = 0; seen_wdata = 0; seen_araddr = 0; seen_wstrb = 0;
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
        bresp_cfg = 0; rresp_cfg = 0; rdata_cfg = 0; slave_flush = 0;
        ARESET = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
        repeat (3) @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        chk("reset_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_err}, 7'h0);
        chk("reset_addr", {AWADDR, ARADDR}, 64'h0);
        chk("reset_data", {WDATA, rsp_rdata}, 64'h0);
        chk("reset_strb_prot", {WSTRB, AWPROT, ARPROT}, 10'h0);
        chk("reset_ready", req_ready, 1);

        // Basic write against an always-ready responder.
        run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);

        // Read with late SLVERR data.
        r_lat = 2; rresp_cfg = 2'b10; rdata_cfg = 32'h1234_5678;
        run_txn(0, 32'h0000_0020, 32'h0, 4'h0);

        // Write address accepted late.
        aw_lat = 4; w_lat = 0; b_lat = 0; bresp_cfg = 2'b00;
        run_txn(1, 32'h0000_0104, 32'hCAFE_F00D, 4'h5);

        // Back-to-back write then read with req_valid held.
        aw_lat = 0; ar_lat = 0; r_lat = 0; rresp_cfg = 2'b00; rdata_cfg = 32'hA5A5_0F0F;
        aw0 = n_aw;
        req_valid = 1; req_write = 1; req_addr = 32'h40; req_wdata = 32'h1111_2222; req_strb = 4'h3;
        @(negedge ACLK);
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin @(negedge ACLK); cyc++; end
        chk("b2b_wr_latency", cyc, 3);
        chk("b2b_ready_at_rsp", req_ready, 1);
        req_write = 0; req_addr = 32'h44;
        @(negedge ACLK);
        req_valid = 0;
        chk("b2b_rd_accepted", {ARVALID, AWVALID, WVALID, ARADDR}, {3'b100, 32'h44});
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin @(negedge ACLK); cyc++; end
        chk("b2b_rd_latency", cyc, 3);
        chk("b2b_rd_data", {rsp_rdata, rsp_err}, {32'hA5A5_0F0F, 1'b0});
        chk("b2b_single_aw", n_aw - aw0, 1);
        @(negedge ACLK);

        // Reset while waiting for read data; the late RVALID must be ignored.
        r_lat = 4; rdata_cfg = 32'h7777_8888;
        p0 = n_rsp; r0 = n_r;
        req_valid = 1; req_write = 0; req_addr = 32'h80;
        @(negedge ACLK);
        req_valid = 0;
        @(negedge ACLK);
        chk("rst_in_rdata", {RREADY, ARVALID}, 2'b10);
        ARESET = 1;
        #1;
        chk("rst_async_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, req_ready},
            7'b0000001);
        @(negedge ACLK);
        ARESET = 0;
        repeat (8) @(negedge ACLK);
        chk("rst_rvalid_ignored", {RVALID, RREADY, req_ready, ARADDR}, {3'b101, 32'h0});
        chk("rst_no_rsp", {8'(n_rsp - p0), 8'(n_r - r0)}, 16'h0);
        slave_flush = 1;
        repeat (2) @(negedge ACLK);
        slave_flush = 0;
        r_lat = 0;

        // Request raised while the write waits for its response.
        b_lat = 4; bresp_cfg = 2'b11; rdata_cfg = 32'h0BAD_F00D; rresp_cfg = 2'b01;
        a_wr = 32'h0000_0200; a_rd = 32'h0000_0ABC; bad = 0;
        req_valid = 1; req_write = 1; req_addr = a_wr; req_wdata = 32'h5555_AAAA; req_strb = 4'h9;
        @(negedge ACLK);
        req_valid = 0;
        cyc = 1;
        while (!BREADY && cyc < 100) begin @(negedge ACLK); cyc++; end
        req_valid = 1; req_write = 0; req_addr = a_rd;
        while (!rsp_valid && cyc < 100) begin
            if (AWADDR !== a_wr || ARVALID !== 1'b0 || req_ready !== 1'b0) bad = 1;
            @(negedge ACLK);
            cyc++;
        end
        chk("busy_held_state", bad, 0);
        chk("busy_wr_latency", cyc, 7);
        chk("busy_wr_err", {rsp_rdata, rsp_err}, {32'h0, 1'b1});
        @(negedge ACLK);
        req_valid = 0;
        chk("busy_req_taken_idle", {ARVALID, ARADDR}, {1'b1, a_rd});
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin @(negedge ACLK); cyc++; end
        chk("busy_rd_data", {rsp_rdata, rsp_err}, {32'h0BAD_F00D, 1'b0});
        @(negedge ACLK);

        // Randomized transactions.
        for (int i = 0; i < 24; i++) begin
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
            b_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
            r_lat = $urandom_range(0, 3);
            bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom); rdata_cfg = $urandom;
            d = $urandom;
            run_txn(1'($urandom), $urandom, d, 4'($urandom));
        end

        chk("protocol_violations", violations, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
